mul_div_unit: RTL and testbench



---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_iter.sv | 38 +++
 rtl/mul_div_unit.sv | 172 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, counter sizing.
// The signed MULT/DIV path is enabled by defining MDU_SIGNED_EN.
package mdu_pkg;

    localparam logic [1:0] MDU_MULTU = 2'b00;
    localparam logic [1:0] MDU_DIVU  = 2'b01;
    localparam logic [1:0] MDU_MULT  = 2'b10;
    localparam logic [1:0] MDU_DIV   = 2'b11;

    localparam int unsigned MDU_WIDTH = 32;

    // Counter must hold 0..WIDTH-1 with one bit of headroom.
    function automatic int unsigned mdu_cnt_w(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

    localparam int unsigned MDU_CNT_W = mdu_cnt_w(MDU_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// One iteration of the shared datapath: shift-add multiply step or restoring divide step.
// The accumulator holds {upper, lower}; lower starts as multiplier or dividend.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next_c
);

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_new;

    always_comb begin
        // Multiply: conditionally add multiplicand to the upper half, then shift right.
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (acc[0]) begin
            add_sum = add_sum + {1'b0, operand};
        end

        // Divide: shift next dividend bit into the remainder and trial-subtract.
        rem_sh  = acc[2*WIDTH-1:WIDTH-1];
        rem_ge  = (rem_sh >= {1'b0, operand});
        rem_new = rem_ge ? WIDTH'(rem_sh - {1'b0, operand}) : rem_sh[WIDTH-1:0];

        if (is_div) begin
            acc_next_c = {rem_new, acc[WIDTH-2:0], rem_ge};
        end else begin
            acc_next_c = {add_sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO; fixed WIDTH-cycle latency.
// Define MDU_SIGNED_EN to make op 10/11 perform signed MULT/DIV; otherwise they alias MULTU/DIVU.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned      CNT_W    = mdu_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [2*WIDTH-1:0] iter_acc_c;
    logic [WIDTH-1:0]   mag_a_c, mag_b_c;
    logic               op_is_div_c;

`ifdef MDU_SIGNED_EN
    logic               neg_q, neg_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;
    logic               sign_a_c, sign_b_c;
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0]   quot_c, rem_c;
`endif

    mdu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .is_div     (is_div_q),
        .acc        (acc_q),
        .operand    (opnd_q),
        .acc_next_c (iter_acc_c)
    );

    // Operand magnitudes at accept time and result sign fix-up on the final iteration.
    always_comb begin
        op_is_div_c = (op == MDU_DIVU) || (op == MDU_DIV);
`ifdef MDU_SIGNED_EN
        sign_a_c = ((op == MDU_MULT) || (op == MDU_DIV)) && rs_data[WIDTH-1];
        sign_b_c = ((op == MDU_MULT) || (op == MDU_DIV)) && rt_data[WIDTH-1];
        mag_a_c  = sign_a_c ? -rs_data : rs_data;
        mag_b_c  = sign_b_c ? -rt_data : rt_data;
        prod_c   = neg_q ? -iter_acc_c : iter_acc_c;
        quot_c   = neg_q ? -iter_acc_c[WIDTH-1:0] : iter_acc_c[WIDTH-1:0];
        if (div0_q) begin
            quot_c = '1;
        end
        rem_c    = neg_rem_q ? -iter_acc_c[2*WIDTH-1:WIDTH] : iter_acc_c[2*WIDTH-1:WIDTH];
`else
        mag_a_c  = rs_data;
        mag_b_c  = rt_data;
`endif
    end

    // Next-state, counter, datapath and HI/LO update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef MDU_SIGNED_EN
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
`endif

        case (state_q)
            RUN: begin
                acc_d = iter_acc_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
`ifdef MDU_SIGNED_EN
                    if (is_div_q) begin
                        hi_d = rem_c;
                        lo_d = quot_c;
                    end else begin
                        hi_d = prod_c[2*WIDTH-1:WIDTH];
                        lo_d = prod_c[WIDTH-1:0];
                    end
`else
                    hi_d = iter_acc_c[2*WIDTH-1:WIDTH];
                    lo_d = iter_acc_c[WIDTH-1:0];
`endif
                end
            end
            // IDLE and DONE both accept a new request.
            default: begin
                state_d = IDLE;
                if (start) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    is_div_d = op_is_div_c;
                    acc_d    = {WIDTH'(0), op_is_div_c ? mag_a_c : mag_b_c};
                    opnd_d   = op_is_div_c ? mag_b_c : mag_a_c;
`ifdef MDU_SIGNED_EN
                    neg_d     = sign_a_c ^ sign_b_c;
                    neg_rem_d = sign_a_c;
                    div0_d    = op_is_div_c && (rt_data == '0);
`endif
                end
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MDU_SIGNED_EN
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef MDU_SIGNED_EN
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed + randomized bench for mul_div_unit against an arithmetic reference model.
// Honours MDU_SIGNED_EN the same way as the design.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op_in = 2'b00;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_err = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op_in),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values, returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic   sgn;
        longint sa, sb, p, q, r;
`ifdef MDU_SIGNED_EN
        sgn = o[1];
`else
        sgn = 1'b0;
`endif
        sa = {{32{sgn & a[31]}}, a};
        sb = {{32{sgn & b[31]}}, b};
        if (!o[0]) begin
            p = sa * sb;
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        op_in   = o;
        rs_data = a;
        rt_data = b;
        tick();
        start   = 1'b0;
        op_in   = 2'($urandom_range(0, 3));
        rs_data = $urandom;
        rt_data = $urandom;
    endtask

    // Count sampled cycles until done; lat=0 means it never came.
    task automatic wait_done(output int lat, output int busy_cnt, output bit hold_ok);
        logic [31:0] h0, l0;
        h0 = hi;
        l0 = lo;
        lat = 0;
        busy_cnt = 0;
        hold_ok = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cnt++;
            if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
            tick();
        end
    endtask

    int          lat, bc, cnt;
    bit          hold;
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] exp_v;
    bit          chained;

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst = 1'b0;
        tick();

        // MULTU max*max: latency and busy window
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bc, hold);
        check("mulmax_lat", 64'(lat), 64'd33);
        check("mulmax_busycnt", 64'(bc), 64'd32);
        check("mulmax_hold", 64'(hold), 64'd1);
        check("mulmax_busy_at_done", 64'(busy), 64'd0);
        check("mulmax_hi", 64'(hi), 64'hFFFF_FFFE);
        check("mulmax_lo", 64'(lo), 64'h0000_0001);
        tick();
        check("mulmax_done_pulse", 64'(done), 64'd0);

        // DIVU 100/7 then divide by zero
        issue(MDU_DIVU, 32'd100, 32'd7);
        wait_done(lat, bc, hold);
        check("div100_lat", 64'(lat), 64'd33);
        check("div100_lo", 64'(lo), 64'd14);
        check("div100_hi", 64'(hi), 64'd2);
        tick();
        issue(MDU_DIVU, 32'd5, 32'd0);
        wait_done(lat, bc, hold);
        check("div0_lat", 64'(lat), 64'd33);
        check("div0_lo", 64'(lo), 64'hFFFF_FFFF);
        check("div0_hi", 64'(hi), 64'h0000_0005);
        tick();

        // Start while busy is ignored; start in done cycle is accepted
        issue(MDU_DIVU, 32'd100, 32'd7);
        for (int i = 0; i < 9; i++) tick();
        start = 1'b1; op_in = MDU_MULTU; rs_data = 32'd3; rt_data = 32'd3;
        tick();
        start = 1'b0;
        wait_done(lat, bc, hold);
        check("ign_lat", 64'(lat), 64'd23);
        check("ign_lo", 64'(lo), 64'd14);
        check("ign_hi", 64'(hi), 64'd2);
        issue(MDU_MULTU, 32'd3, 32'd3);
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done(lat, bc, hold);
        check("b2b_lat", 64'(lat), 64'd33);
        check("b2b_hold", 64'(hold), 64'd1);
        check("b2b_lo", 64'(lo), 64'd9);
        check("b2b_hi", 64'(hi), 64'd0);
        tick();

        // Give HI/LO a nonzero value, then abort mid-run with reset
        issue(MDU_MULTU, 32'd6, 32'd7);
        wait_done(lat, bc, hold);
        check("mul67_lo", 64'(lo), 64'd42);
        tick();
        issue(MDU_MULTU, 32'd6, 32'd7);
        for (int i = 0; i < 15; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) cnt++;
            tick();
        end
        check("abort_no_done", 64'(cnt), 64'd0);

        // rst and start on the same edge: start dropped
        rst = 1'b1; start = 1'b1; op_in = MDU_MULTU; rs_data = 32'd5; rt_data = 32'd5;
        tick();
        rst = 1'b0; start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) cnt++;
            tick();
        end
        check("rst_start_drop", 64'(cnt), 64'd0);

`ifdef MDU_SIGNED_EN
        issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_done(lat, bc, hold);
        check("smul_lat", 64'(lat), 64'd33);
        check("smul_hi", 64'(hi), 64'hFFFF_FFFF);
        check("smul_lo", 64'(lo), 64'hFFFF_FFFA);
        tick();
        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bc, hold);
        check("sdiv_lat", 64'(lat), 64'd33);
        check("sdiv_lo", 64'(lo), 64'hFFFF_FFFD);
        check("sdiv_hi", 64'(hi), 64'hFFFF_FFFF);
        tick();
`else
        issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_done(lat, bc, hold);
        check("umul_alias_lat", 64'(lat), 64'd33);
        check("umul_alias_hi", 64'(hi), 64'h0000_0002);
        check("umul_alias_lo", 64'(lo), 64'hFFFF_FFFA);
        tick();
`endif

        // Randomized ops, some issued back-to-back in the done cycle
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 200));
            exp_v = model(o, a, b);
            issue(o, a, b);
            wait_done(lat, bc, hold);
            check("rnd_lat", 64'(lat), 64'd33);
            check("rnd_hold", 64'(hold), 64'd1);
            check("rnd_hi", 64'(hi), 64'(exp_v[63:32]));
            check("rnd_lo", 64'(lo), 64'(exp_v[31:0]));
            chained = 1'($urandom_range(0, 1));
            if (!chained) tick();
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
